// File: rtl/halt_dump_ctrl.sv
// Halt detector and data-RAM dump engine: stalls the CPU on a halt pattern or snapshot request,
// drains, then streams BASE_ADDR..BASE_ADDR+DEPTH-1 over valid/ready (one word per >=3 cycles).
module halt_dump_ctrl #(
    parameter int                 DATA_W       = 32,
    parameter int                 ADDR_W       = 9,
    parameter int                 DEPTH        = 512,
    parameter int                 BASE_ADDR    = 0,
    parameter int                 INSTR_W      = 32,
    parameter logic [INSTR_W-1:0] HALT_PATTERN = 32'hFFFFFFFF,
    parameter int                 DRAIN_CYCLES = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [INSTR_W-1:0] instr_d_i,
    input  logic              dump_req_i,
    output logic              cpu_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic              dout_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int                IDX_W      = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);
    localparam logic [7:0]        DRAIN_LAST = 8'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_DRAIN = 3'd1,
        S_READ  = 3'd2,
        S_CAPT  = 3'd3,
        S_SEND  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // A zero drain period skips the DRAIN state entirely.
    localparam state_t S_ENTRY = (DRAIN_CYCLES == 0) ? S_READ : S_DRAIN;

    state_t              state_q, state_d;
    logic                halted_q, halted_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          drain_q, drain_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                halt_hit;

    assign halt_hit = (instr_d_i == HALT_PATTERN);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_RUN;
            halted_q <= 1'b0;
            idx_q    <= '0;
            drain_q  <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            idx_q    <= idx_d;
            drain_q  <= drain_d;
            dout_q   <= dout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        idx_d    = idx_q;
        drain_d  = '0;
        dout_d   = dout_q;
        case (state_q)
            S_RUN: begin
                // Halt takes priority over a coincident snapshot request.
                if (halt_hit) begin
                    halted_d = 1'b1;
                    state_d  = S_ENTRY;
                end else if (dump_req_i) begin
                    state_d  = S_ENTRY;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_READ;
                end else begin
                    drain_d = drain_q + 8'd1;
                end
            end
            S_READ: state_d = S_CAPT;
            S_CAPT: begin
                dout_d  = mem_rdata_i;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (dout_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = halted_q ? S_DONE : S_RUN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                if (dump_req_i) begin
                    idx_d   = '0;
                    state_d = S_READ;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        cpu_stall_o  = halted_q || (state_q != S_RUN);
        busy_o       = (state_q == S_DRAIN) || (state_q == S_READ) ||
                       (state_q == S_CAPT)  || (state_q == S_SEND);
        done_o       = (state_q == S_DONE);
        dout_valid_o = (state_q == S_SEND);
        dout_last_o  = (state_q == S_SEND) && (idx_q == LAST_IDX);
        mem_addr_o   = BASE + ADDR_W'(idx_q);
        dout_o       = dout_q;
    end

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// Scoreboard bench for halt_dump_ctrl: DEPTH=8, BASE_ADDR=100, DRAIN_CYCLES=3, RAM[i]=i*3.
module tb_halt_dump_ctrl;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 9;
    localparam int INSTR_W   = 32;
    localparam int DEPTH     = 8;
    localparam int BASE      = 100;
    localparam int DRAIN     = 3;
    localparam logic [INSTR_W-1:0] HALT = 32'hFFFFFFFF;
    // Cycle counts measured from the trigger edge.
    localparam int FIRST_VLD = 3 + DRAIN;
    localparam int DONE_LAT  = 3 + DRAIN + 3 * (DEPTH - 1) + 1;
    localparam int REDUMP_LAT = 3 * DEPTH + 1;

    logic               clk;
    logic               rst_n;
    logic [INSTR_W-1:0] instr_d;
    logic               dump_req;
    logic               cpu_stall;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_rdata;
    logic [DATA_W-1:0]  dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               dout_last;
    logic               busy;
    logic               done;

    int compared   = 0;
    int mismatched = 0;
    bit rnd_rdy    = 1'b0;

    logic [DATA_W:0]   exp_q[$];
    logic [DATA_W-1:0] ram [0:511];

    halt_dump_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE),
        .INSTR_W(INSTR_W), .HALT_PATTERN(HALT), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .instr_d_i(instr_d), .dump_req_i(dump_req),
        .cpu_stall_o(cpu_stall), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
        .dout_o(dout), .dout_valid_o(dout_valid), .dout_ready_i(dout_ready),
        .dout_last_o(dout_last), .busy_o(busy), .done_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= ram[mem_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pass(input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back({(k == DEPTH - 1) ? 1'b1 : 1'b0, DATA_W'((BASE + k) * 3)});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_stall"}, 64'(cpu_stall), 64'd0);
        chk({tag, "_busy"},  64'(busy),      64'd0);
        chk({tag, "_done"},  64'(done),      64'd0);
        chk({tag, "_valid"}, 64'(dout_valid), 64'd0);
        chk({tag, "_last"},  64'(dout_last), 64'd0);
        chk({tag, "_dout"},  64'(dout),      64'd0);
        chk({tag, "_addr"},  64'(mem_addr),  64'(BASE));
    endtask

    // Pseudo-random back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) dout_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks hold stability under back-pressure.
    logic              held_vld = 1'b0;
    logic [DATA_W:0]   held_dat;
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid) begin
                if (held_vld) chk("hold_stable", 64'({dout_last, dout}), 64'(held_dat));
                if (dout_ready) begin
                    held_vld = 1'b0;
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_word: got %0h expected none", {dout_last, dout});
                    end else begin
                        chk("dout_word", 64'({dout_last, dout}), 64'(exp_q.pop_front()));
                    end
                end else begin
                    held_vld = 1'b1;
                    held_dat = {dout_last, dout};
                end
            end else begin
                held_vld = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 512; i++) ram[i] = DATA_W'(i * 3);
        rst_n = 1'b0; instr_d = '0; dump_req = 1'b0; dout_ready = 1'b0;
        repeat (3) tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick(); tick();

        // Snapshot under random back-pressure; halt pattern and held request must be ignored.
        rnd_rdy = 1'b1;
        dump_req = 1'b1;
        push_pass(DEPTH);
        tick();
        chk("snap_stall", 64'(cpu_stall), 64'd1);
        chk("snap_busy",  64'(busy),      64'd1);
        instr_d = HALT;
        repeat (12) tick();
        instr_d = '0; dump_req = 1'b0;
        n = 0;
        while ((cpu_stall || exp_q.size() != 0) && n < 400) begin tick(); n++; end
        chk("snap_in_time", 64'(n < 400), 64'd1);
        chk("snap_done",  64'(done),      64'd0);
        chk("snap_stall_drop", 64'(cpu_stall), 64'd0);
        chk("snap_busy_drop",  64'(busy),      64'd0);
        chk("snap_addr_rewind", 64'(mem_addr), 64'(BASE));

        // Halt and snapshot on the same edge: halt wins, ends in DONE.
        rnd_rdy = 1'b0; dout_ready = 1'b1;
        tick();
        instr_d = HALT; dump_req = 1'b1;
        push_pass(DEPTH);
        tick();
        instr_d = '0; dump_req = 1'b0;
        chk("halt_stall", 64'(cpu_stall), 64'd1);
        n = 1;
        while (!dout_valid && n < 60) begin tick(); n++; end
        chk("first_valid_lat", 64'(n), 64'(FIRST_VLD));
        chk("first_addr_word", 64'(dout), 64'(BASE * 3));
        while (!done && n < 200) begin tick(); n++; end
        chk("done_lat", 64'(n), 64'(DONE_LAT));
        chk("done_stall", 64'(cpu_stall), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("halt_drained", 64'(exp_q.size()), 64'd0);

        // Re-dump from DONE.
        dump_req = 1'b1;
        push_pass(DEPTH);
        tick();
        dump_req = 1'b0;
        chk("redump_done_low", 64'(done), 64'd0);
        chk("redump_busy", 64'(busy), 64'd1);
        n = 1;
        while (!done && n < 200) begin tick(); n++; end
        chk("redump_lat", 64'(n), 64'(REDUMP_LAT));
        chk("redump_drained", 64'(exp_q.size()), 64'd0);

        // Reset while word 7 sits in SEND.
        dump_req = 1'b1;
        push_pass(DEPTH - 1);
        tick();
        dump_req = 1'b0;
        n = 0;
        while (!(dout_valid && dout_last) && n < 100) begin tick(); n++; end
        dout_ready = 1'b0;
        chk("word7_reached", 64'(n < 100), 64'd1);
        chk("word7_value", 64'(dout), 64'((BASE + DEPTH - 1) * 3));
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        tick();
        rst_n = 1'b1;
        dout_ready = 1'b1;
        tick();
        chk("post_rst_stall", 64'(cpu_stall), 64'd0);

        // Fresh halt after reset restarts from BASE_ADDR.
        instr_d = HALT;
        push_pass(DEPTH);
        tick();
        instr_d = '0;
        n = 1;
        while (!done && n < 200) begin tick(); n++; end
        chk("restart_done_lat", 64'(n), 64'(DONE_LAT));
        repeat (3) tick();
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
